// File: rtl/clk_en_sched.sv
// clk_en_sched: clock-enable scheduler for the fastclk domain.
// Emits one-cycle enable strobes per channel at programmable divide ratios,
// keeps all channels phase-aligned and applies divisor changes only at a
// common alignment point (the next channel-0 strobe).
//
// Ports:
//   fastclk    sole clock, posedge
//   reset_h    synchronous reset, active-high
//   run        1 = schedule enables, 0 = idle
//   cfg_valid  divisor write request
//   cfg_ready  write accepted when cfg_valid && cfg_ready (low in RESYNC)
//   cfg_ch     target channel (>= NCH accepted and ignored)
//   cfg_div    divisor, 0 treated as 1
//   en_o       registered enable strobes
//   aligned_o  registered, high when all channels strobe together
//   busy_o     high when not IDLE
//   ch0_count  wrapping count of en_o[0] strobes
//   tog_o      (only with CLK_SCHED_TOGGLE_EN) toggles on every strobe
//
// Optional feature macro: CLK_SCHED_TOGGLE_EN
module clk_en_sched #(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter int CW  = 32
) (
    input  logic            fastclk,
    input  logic            reset_h,
    input  logic            run,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [1:0]      cfg_ch,
    input  logic [DW-1:0]   cfg_div,
    output logic [NCH-1:0]  en_o,
    output logic            aligned_o,
    output logic            busy_o,
    output logic [CW-1:0]   ch0_count
`ifdef CLK_SCHED_TOGGLE_EN
    ,
    output logic [NCH-1:0]  tog_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESYNC
    } state_t;

    localparam logic [DW-1:0] ONE = DW'(1);
    localparam logic [DW-1:0] DEF = DW'(2);

    state_t         state;
    state_t         state_nxt;

    logic [DW-1:0]  shadow     [NCH];
    logic [DW-1:0]  shadow_nxt [NCH];
    logic [DW-1:0]  active     [NCH];
    logic [DW-1:0]  active_nxt [NCH];
    logic [DW-1:0]  cnt        [NCH];
    logic [DW-1:0]  cnt_nxt    [NCH];

    logic [NCH-1:0] en_nxt;
    logic           aligned_nxt;
    logic           wr_hit;

    function automatic logic [DW-1:0] eff_div(input logic [DW-1:0] d);
        return (d == '0) ? ONE : d;
    endfunction

    assign cfg_ready = (state != RESYNC);
    assign busy_o    = (state != IDLE);

    // Writes to nonexistent channels complete the handshake but do nothing.
    assign wr_hit = cfg_valid && cfg_ready && (int'(cfg_ch) < NCH);

    always_comb begin
        state_nxt   = state;
        en_nxt      = '0;
        aligned_nxt = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            shadow_nxt[i] = shadow[i];
            active_nxt[i] = active[i];
            cnt_nxt[i]    = cnt[i];
            if (wr_hit && int'(cfg_ch) == i)
                shadow_nxt[i] = eff_div(cfg_div);
        end

        unique case (state)
            IDLE: begin
                for (int i = 0; i < NCH; i++)
                    cnt_nxt[i] = '0;
                if (run) begin
                    state_nxt = RUN;
                    en_nxt    = '1;
                    for (int i = 0; i < NCH; i++) begin
                        active_nxt[i] = shadow_nxt[i];
                        cnt_nxt[i]    = shadow_nxt[i] - ONE;
                    end
                end
            end
            RUN, RESYNC: begin
                if (!run) begin
                    state_nxt = IDLE;
                    for (int i = 0; i < NCH; i++)
                        cnt_nxt[i] = '0;
                end else if (state == RESYNC && cnt[0] == '0) begin
                    // Alignment point: every channel restarts on the new divisor.
                    state_nxt = RUN;
                    en_nxt    = '1;
                    for (int i = 0; i < NCH; i++) begin
                        active_nxt[i] = shadow_nxt[i];
                        cnt_nxt[i]    = shadow_nxt[i] - ONE;
                    end
                end else begin
                    for (int i = 0; i < NCH; i++) begin
                        if (cnt[i] == '0) begin
                            en_nxt[i]  = 1'b1;
                            cnt_nxt[i] = active[i] - ONE;
                        end else begin
                            cnt_nxt[i] = cnt[i] - ONE;
                        end
                    end
                    if (state == RUN && wr_hit)
                        state_nxt = RESYNC;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        aligned_nxt = &en_nxt;
    end

    always_ff @(posedge fastclk) begin
        if (reset_h) begin
            state     <= IDLE;
            en_o      <= '0;
            aligned_o <= 1'b0;
            ch0_count <= '0;
            for (int i = 0; i < NCH; i++) begin
                shadow[i] <= DEF;
                active[i] <= DEF;
                cnt[i]    <= '0;
            end
        end else begin
            state     <= state_nxt;
            en_o      <= en_nxt;
            aligned_o <= aligned_nxt;
            if (en_nxt[0])
                ch0_count <= ch0_count + CW'(1);
            for (int i = 0; i < NCH; i++) begin
                shadow[i] <= shadow_nxt[i];
                active[i] <= active_nxt[i];
                cnt[i]    <= cnt_nxt[i];
            end
        end
    end

`ifdef CLK_SCHED_TOGGLE_EN
    // Debug square wave only; never used as a clock.
    always_ff @(posedge fastclk) begin
        if (reset_h)
            tog_o <= '0;
        else if (state_nxt == IDLE)
            tog_o <= '0;
        else
            tog_o <= tog_o ^ en_nxt;
    end
`endif

endmodule

// File: tb/tb_clk_en_sched.sv
// tb_clk_en_sched: randomized self-checking bench for clk_en_sched.
// Reference model schedules strobes from elapsed cycles since alignment.
module tb_clk_en_sched;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int CW  = 4;

    logic           fastclk = 1'b0;
    logic           reset_h = 1'b1;
    logic           run = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [1:0]     cfg_ch = '0;
    logic [DW-1:0]  cfg_div = '0;
    logic [NCH-1:0] en_o;
    logic           aligned_o;
    logic           busy_o;
    logic [CW-1:0]  ch0_count;
`ifdef CLK_SCHED_TOGGLE_EN
    logic [NCH-1:0] tog_o;
`endif

    clk_en_sched #(
        .NCH(NCH),
        .DW (DW),
        .CW (CW)
    ) dut (
        .fastclk  (fastclk),
        .reset_h  (reset_h),
        .run      (run),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .en_o     (en_o),
        .aligned_o(aligned_o),
        .busy_o   (busy_o),
        .ch0_count(ch0_count)
`ifdef CLK_SCHED_TOGGLE_EN
        ,
        .tog_o    (tog_o)
`endif
    );

    always #5 fastclk = ~fastclk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 run, 2 resync; m_k = cycles since last alignment.
    int             m_sh  [NCH];
    int             m_act [NCH];
    int             m_k = 0;
    int             m_mode = 0;
    int             m_cnt = 0;
    logic [NCH-1:0] m_en = '0;
    logic [NCH-1:0] m_tog = '0;

    task automatic tick();
        bit hit;
        hit = cfg_valid && (m_mode != 2) && (int'(cfg_ch) < NCH);
        @(posedge fastclk);
        if (reset_h) begin
            m_mode = 0;
            m_k    = 0;
            m_cnt  = 0;
            m_en   = '0;
            m_tog  = '0;
            for (int i = 0; i < NCH; i++) begin
                m_sh[i]  = 2;
                m_act[i] = 2;
            end
        end else begin
            if (hit)
                m_sh[cfg_ch] = (cfg_div == 0) ? 1 : int'(cfg_div);
            if (m_mode == 0) begin
                m_en = '0;
                if (run) begin
                    for (int i = 0; i < NCH; i++)
                        m_act[i] = m_sh[i];
                    m_k    = 0;
                    m_mode = 1;
                    m_en   = '1;
                end
            end else if (!run) begin
                m_mode = 0;
                m_k    = 0;
                m_en   = '0;
            end else begin
                m_k++;
                if (m_mode == 2 && (m_k % m_act[0]) == 0) begin
                    for (int i = 0; i < NCH; i++)
                        m_act[i] = m_sh[i];
                    m_k    = 0;
                    m_mode = 1;
                    m_en   = '1;
                end else begin
                    for (int i = 0; i < NCH; i++)
                        m_en[i] = ((m_k % m_act[i]) == 0);
                    if (m_mode == 1 && hit)
                        m_mode = 2;
                end
            end
            if (m_en[0])
                m_cnt = (m_cnt + 1) % (1 << CW);
            if (m_mode == 0)
                m_tog = '0;
            else
                m_tog = m_tog ^ m_en;
        end
        #1;
        check("en_o", en_o, m_en);
        check("aligned_o", aligned_o, (m_en == '1));
        check("busy_o", busy_o, (m_mode != 0));
        check("cfg_ready", cfg_ready, (m_mode != 2));
        check("ch0_count", ch0_count, m_cnt);
`ifdef CLK_SCHED_TOGGLE_EN
        check("tog_o", tog_o, m_tog);
`endif
    endtask

    task automatic wr(input int ch, input int d);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = DW'(d);
        tick();
        cfg_valid = 1'b0;
    endtask

    int n_al;
    int n_lo;

    initial begin
        reset_h = 1'b1;
        tick();
        tick();
        check("rst_en", en_o, 0);
        check("rst_cnt", ch0_count, 0);

        // Default divisors (2): alternating strobes.
        reset_h = 1'b0;
        run = 1'b1;
        repeat (100) tick();
        check("cnt100", ch0_count, 50 % (1 << CW));

        // Program in IDLE, then run.
        run = 1'b0;
        tick();
        wr(0, 1);
        wr(1, 3);
        wr(2, 4);
        wr(3, 0);
        run = 1'b1;
        n_al = 0;
        repeat (24) begin
            tick();
            n_al += int'(aligned_o);
        end
        check("aligned_12", n_al, 2);

        // ch0 -> 5 via resync, then ch1 -> 7 two cycles after a ch0 strobe.
        wr(0, 5);
        tick();
        check("ch0_strobe", en_o, 4'hF);
        tick();
        wr(1, 7);
        n_lo = 0;
        while (!cfg_ready && n_lo < 10) begin
            n_lo++;
            tick();
        end
        check("resync_len", n_lo, 3);
        check("resync_align", en_o, 4'hF);
        repeat (20) tick();

        // Drop run mid-resync, then re-raise.
        wr(2, 6);
        run = 1'b0;
        tick();
        check("drop_busy", busy_o, 0);
        check("drop_ready", cfg_ready, 1);
        run = 1'b1;
        tick();
        check("rerun_en", en_o, 4'hF);
        repeat (20) tick();

        // ch2 divisor 3 (square wave of period 6 on tog_o[2] when enabled).
        wr(2, 3);
        repeat (30) tick();

        // Randomized traffic.
        repeat (3000) begin
            run       = ($urandom_range(0, 99) < 95);
            reset_h   = ($urandom_range(0, 499) == 0);
            cfg_valid = ($urandom_range(0, 9) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_div   = DW'($urandom_range(0, 6));
            tick();
        end

        // Counter wrap and reset mid-run.
        cfg_valid = 1'b0;
        run = 1'b0;
        reset_h = 1'b1;
        tick();
        reset_h = 1'b0;
        wr(0, 1);
        run = 1'b1;
        repeat (15) tick();
        check("pre_wrap", ch0_count, 15);
        tick();
        check("wrap", ch0_count, 0);
        repeat (5) tick();
        reset_h = 1'b1;
        tick();
        check("mid_rst_en", en_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_cnt", ch0_count, 0);
        reset_h = 1'b0;
        run = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_en_sched.md
Name: clk_en_sched

Overview:
- Clock-enable scheduler for the fastclk domain. It replaces free-running divided clocks (register-toggle clocks) with single-cycle enable strobes, one per channel, at programmable divide ratios.
- Channels start phase-aligned, and divisor changes apply only at a common alignment point.
- Channel 0 drives a wrapping event counter, the enable-based equivalent of a count clocked by a divided clock.

Parameters:
- NCH, 4, number of enable channels (1..4).
- DW, 8, divisor width.
- CW, 32, width of the channel-0 event counter.

Ports:
- fastclk  input  1  sole clock; all logic on posedge.
- reset_h  input  1  synchronous reset, active-high.
- run  input  1  level; 1 = schedule enables, 0 = idle.
- cfg_valid  input  1  divisor write request.
- cfg_ready  output  1  write accepted when cfg_valid && cfg_ready at a posedge.
- cfg_ch  input  2  target channel; values >= NCH are accepted and ignored.
- cfg_div  input  DW  divisor D; 0 is treated as 1.
- en_o  output  NCH  registered one-cycle enable strobes.
- aligned_o  output  1  registered; 1 on cycles where all channels strobe together.
- busy_o  output  1  1 when state != IDLE.
- ch0_count  output  CW  count of en_o[0] strobes.

Behaviour:
- Reset (reset_h high at posedge; overrides everything):
  - state=IDLE; en_o=0; aligned_o=0; ch0_count=0.
  - Per-channel down-counters=0.
  - Shadow and active divisors = 2 (half rate).
  - cfg_ready=1.
- Per-channel state: shadow divisor (written by cfg), active divisor (used for scheduling), down-counter cnt[i].
- Divisor D (effective max(D,1)): en_o[i] strobes exactly once every D fastclk cycles. D=1 strobes every cycle.
- IDLE:
  - en_o=0, aligned_o=0, counters held at 0.
  - Accepted cfg writes update the shadow only.
  - run=1 at a posedge → RUN. On that same edge: active←shadow, all cnt[i]←active_new-1, en_o=all ones, aligned_o=1.
- RUN, each posedge, per channel:
  - If cnt[i]==0: en_o[i]=1, cnt[i]←D-1.
  - Otherwise: en_o[i]=0, cnt[i]←cnt[i]-1.
  - aligned_o is 0 unless the strobe pattern is all-ones.
- RESYNC:
  - Entry: an accepted cfg write in RUN updates the shadow and moves to RESYNC on the same edge. The write to the shadow is not visible on en_o until alignment.
  - cfg_ready=0 while in RESYNC.
  - Channels keep running on the old active divisors.
  - Alignment: at the posedge where cnt[0]==0, active←shadow for all channels, all cnt[i]←newD-1, en_o=all ones (including channels not otherwise due), aligned_o=1, state→RUN.
- run=0 sampled in RUN or RESYNC → IDLE on that edge:
  - en_o=0, aligned_o=0, counters←0.
  - A pending shadow is kept and applied on the next IDLE→RUN.
- Simultaneous run=0 and accepted cfg write in RUN: the shadow is written and state goes to IDLE, not RESYNC.
- A cfg write with cfg_ch >= NCH: handshake completes, no register changes, and it does not trigger RESYNC.
- ch0_count: increments on every edge that sets en_o[0]=1, wraps 2^CW-1→0. Cleared only by reset; it holds value through IDLE.
- busy_o is combinational from state.
- cfg_ready = (state != RESYNC).

Optional Feature:
- Macro: CLK_SCHED_TOGGLE_EN.
- Defined: adds output tog_o [NCH]. tog_o[i] inverts on every edge that sets en_o[i]=1, giving a square wave of period 2·D fastclk cycles for debug and scope probing. Cleared to 0 by reset and on entry to IDLE. It is never used as a clock internally.
- Undefined: tog_o port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then run=1 with default divisors → first cycle en_o=4'b1111, aligned_o=1; then en_o alternates 0000/1111; ch0_count=50 after 100 RUN cycles.
- In IDLE, write ch0=1, ch1=3, ch2=4, ch3=0; then run=1 → en_o[0] every cycle; en_o[1] every 3rd; en_o[2] every 4th; en_o[3] every cycle (0 treated as 1); aligned_o every 12 cycles.
- In RUN with ch0 D=5, write ch1=7 two cycles after a ch0 strobe → cfg_ready=0 for 3 cycles; all-ones strobe and aligned_o=1 at the next ch0 strobe; ch1 then strobes every 7 cycles.
- Drop run mid-RESYNC → next cycle en_o=0, busy_o=0, cfg_ready=1; re-raise run → new divisor active from the first RUN cycle with all-ones strobe.
- Preload by forcing ch0_count to 2^CW-2 (or CW=4 build) → wraps to 0 after two en_o[0] strobes; reset_h mid-RUN → all outputs reset values on the next edge.
- CLK_SCHED_TOGGLE_EN with ch2 D=3 → tog_o[2] period 6 cycles, 50% duty; undefined build elaborates without tog_o.
